// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM
// states, ALU operation codes, datapath select codes and the control word.
package mips_ctrl_pkg;

  // Primary opcodes (Instr[31:26])
  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SLTI = 6'd10;
  localparam logic [5:0] OP_ANDI = 6'd12;
  localparam logic [5:0] OP_ORI  = 6'd13;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  // FSM state encodings; these values are visible on state_dbg
  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADR   = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE   = 4'd6;
  localparam logic [3:0] S_ALU_WB    = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_ITYPE_EX  = 4'd9;
  localparam logic [3:0] S_ITYPE_WB  = 4'd10;
  localparam logic [3:0] S_JUMP      = 4'd11;

  // ALUOp codes; funct decoding happens in the ALU control, not here
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  // Conditional PC write codes
  localparam logic [1:0] PCWC_NONE  = 2'b00;
  localparam logic [1:0] PCWC_ZERO  = 2'b01;
  localparam logic [1:0] PCWC_NZERO = 2'b10;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU B operand selects
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Instruction classes steering the DECODE dispatch
  typedef enum logic [2:0] {
    CLS_MEM,
    CLS_RTYPE,
    CLS_BRANCH,
    CLS_ITYPE,
    CLS_JUMP,
    CLS_ILLEGAL
  } op_class_e;

  // Immediate-ALU setup shared by ITYPE_EX and ITYPE_WB
  typedef struct packed {
    logic       ext_op;
    logic [2:0] alu_op;
  } imm_alu_t;

  // Full control word produced by the output decoder
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       ext_op;
    logic       reg_dst;
    logic [1:0] pc_src;
    logic [1:0] alu_src_b;
    logic       ir_write;
    logic       mem_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] pc_write_cond;
    logic [2:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Map an opcode onto its dispatch class; disabled opcodes count as illegal
  function automatic op_class_e classify_op(input logic [5:0] op,
                                            input logic       en_bne,
                                            input logic       en_logic_imm);
    op_class_e cls;
    case (op)
      OP_LW, OP_SW:              cls = CLS_MEM;
      OP_R:                      cls = CLS_RTYPE;
      OP_BEQ:                    cls = CLS_BRANCH;
      OP_BNE:                    cls = en_bne ? CLS_BRANCH : CLS_ILLEGAL;
      OP_ADDI:                   cls = CLS_ITYPE;
      OP_SLTI, OP_ANDI, OP_ORI:  cls = en_logic_imm ? CLS_ITYPE : CLS_ILLEGAL;
      OP_J:                      cls = CLS_JUMP;
      default:                   cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  // Extension mode and ALU operation for the immediate-ALU instructions;
  // logical immediates zero-extend, arithmetic ones sign-extend
  function automatic imm_alu_t imm_alu_setup(input logic [5:0] op);
    imm_alu_t s;
    case (op)
      OP_SLTI: s = '{ext_op: 1'b1, alu_op: ALU_SLT};
      OP_ANDI: s = '{ext_op: 1'b0, alu_op: ALU_AND};
      OP_ORI:  s = '{ext_op: 1'b0, alu_op: ALU_OR};
      default: s = '{ext_op: 1'b1, alu_op: ALU_ADD};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational output decoder: (state, opcode) -> control word.
// Pure Moore decode except for the FETCH strobes, which wait for the
// memory to complete, and the opcode-dependent fields in DECODE/BRANCH/ITYPE.
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter bit EN_BNE       = 1'b1,
  parameter bit EN_LOGIC_IMM = 1'b1
) (
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  imm_alu_t imm_setup;

  assign imm_setup = imm_alu_setup(opcode);

  // Build the control word for the current state; unlisted fields stay 0
  always_comb begin
    // NOTE: the idle default covers every field on every path, so no latch can be inferred.
    ctrl = CTRL_IDLE;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.ext_op     = 1'b1;
        ctrl.illegal_op = (classify_op(opcode, EN_BNE, EN_LOGIC_IMM) == CLS_ILLEGAL);
      end
      S_MEM_ADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.ext_op    = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        // Held through a stall so the memory sees a stable request
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_src        = PCSRC_ALUOUT;
        ctrl.pc_write_cond = (opcode == OP_BNE) ? PCWC_NZERO : PCWC_ZERO;
      end
      S_ITYPE_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.ext_op    = imm_setup.ext_op;
        ctrl.alu_op    = imm_setup.alu_op;
      end
      S_ITYPE_WB: begin
        // ExtOp/ALUOp kept stable while the result is written back
        ctrl.reg_write = 1'b1;
        ctrl.ext_op    = imm_setup.ext_op;
        ctrl.alu_op    = imm_setup.alu_op;
      end
      S_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control unit: state register and next-state logic,
// with output decoding delegated to mc_ctrl_decode. Outputs are forced
// to 0 while rst is high.
module mc_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit EN_BNE        = 1'b1,
  parameter bit EN_LOGIC_IMM  = 1'b1
) (
  input  logic        cclk,
  input  logic        rst,
  input  logic [31:0] Instr,
  input  logic        mem_ready,
  output logic        MemReq,
  output logic        IorD,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic        ExtOp,
  output logic        RegDst,
  output logic [1:0]  PCSrc,
  output logic [1:0]  ALUSrcB,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  PCWriteCond,
  output logic [2:0]  ALUOp,
  output logic        illegal_op,
  output logic [3:0]  state_dbg
);

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [5:0] opcode;
  logic       ready;
  op_class_e  op_class;
  ctrl_t      ctrl;
  ctrl_t      ctrl_out;
  logic       unused_instr_bits;

  assign opcode            = Instr[31:26];
  assign unused_instr_bits = ^Instr[25:0];

  // Without the handshake every memory access is taken to finish at once
  assign ready    = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign op_class = classify_op(opcode, EN_BNE, EN_LOGIC_IMM);

  // Next-state selection: dispatch in DECODE, stall on memory states
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:     state_nxt = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_class)
          CLS_MEM:    state_nxt = S_MEM_ADR;
          CLS_RTYPE:  state_nxt = S_EXECUTE;
          CLS_BRANCH: state_nxt = S_BRANCH;
          CLS_ITYPE:  state_nxt = S_ITYPE_EX;
          CLS_JUMP:   state_nxt = S_JUMP;
          default:    state_nxt = S_FETCH;
        endcase
      end
      S_MEM_ADR:   state_nxt = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_nxt = ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_nxt = S_FETCH;
      S_MEM_WRITE: state_nxt = ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_nxt = S_ALU_WB;
      S_ALU_WB:    state_nxt = S_FETCH;
      S_BRANCH:    state_nxt = S_FETCH;
      S_ITYPE_EX:  state_nxt = S_ITYPE_WB;
      S_ITYPE_WB:  state_nxt = S_FETCH;
      S_JUMP:      state_nxt = S_FETCH;
      default:     state_nxt = S_FETCH;
    endcase
  end

  // State register; reset wins over any pending stall
  always_ff @(posedge cclk) begin
    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  mc_ctrl_decode #(
    .EN_BNE       (EN_BNE),
    .EN_LOGIC_IMM (EN_LOGIC_IMM)
  ) u_decode (
    .state     (state),
    .opcode    (opcode),
    .mem_ready (ready),
    .ctrl      (ctrl)
  );

  // Silence every output while reset is asserted
  assign ctrl_out = rst ? CTRL_IDLE : ctrl;

  assign MemReq      = ctrl_out.mem_req;
  assign IorD        = ctrl_out.iord;
  assign MemtoReg    = ctrl_out.mem_to_reg;
  assign ALUSrcA     = ctrl_out.alu_src_a;
  assign ExtOp       = ctrl_out.ext_op;
  assign RegDst      = ctrl_out.reg_dst;
  assign PCSrc       = ctrl_out.pc_src;
  assign ALUSrcB     = ctrl_out.alu_src_b;
  assign IRWrite     = ctrl_out.ir_write;
  assign MemWrite    = ctrl_out.mem_write;
  assign PCWrite     = ctrl_out.pc_write;
  assign RegWrite    = ctrl_out.reg_write;
  assign PCWriteCond = ctrl_out.pc_write_cond;
  assign ALUOp       = ctrl_out.alu_op;
  assign illegal_op  = ctrl_out.illegal_op;
  assign state_dbg   = rst ? S_FETCH : state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit. Stimulus pushes the expected
// per-cycle output vector; a negedge monitor pops and compares.
// dut_a: default parameters. dut_b: no handshake, BNE and logic-imm disabled.
module tb_mc_control_unit;

  localparam logic [31:0] I_LW   = 32'h8C00_0000;
  localparam logic [31:0] I_SW   = 32'hAC00_0000;
  localparam logic [31:0] I_R    = 32'h0000_0000;
  localparam logic [31:0] I_BEQ  = 32'h1000_0000;
  localparam logic [31:0] I_BNE  = 32'h1400_0000;
  localparam logic [31:0] I_ORI  = 32'h3400_0000;
  localparam logic [31:0] I_ADDI = 32'h2000_0000;
  localparam logic [31:0] I_J    = 32'h0800_0000;
  localparam logic [31:0] I_BAD  = 32'hFC00_0000;

  logic cclk;
  logic rst_a, rst_b;
  logic [31:0] instr_a, instr_b;
  logic ready_a, ready_b;

  logic a_memreq, a_iord, a_m2r, a_srca, a_ext, a_rdst, a_irw, a_mw, a_pcw, a_rw, a_ill;
  logic [1:0] a_pcsrc, a_srcb, a_pcwc;
  logic [2:0] a_aluop;
  logic [3:0] a_state;
  logic b_memreq, b_iord, b_m2r, b_srca, b_ext, b_rdst, b_irw, b_mw, b_pcw, b_rw, b_ill;
  logic [1:0] b_pcsrc, b_srcb, b_pcwc;
  logic [2:0] b_aluop;
  logic [3:0] b_state;

  logic [23:0] act_a, act_b;
  logic [23:0] qa_v[$];
  string       qa_t[$];
  logic [23:0] qb_v[$];
  string       qb_t[$];
  logic [23:0] mon_exp;
  string       mon_tag;

  int checks = 0;
  int errors = 0;

  logic [23:0] E_ZERO, E_FETCH, E_FETCH_W, E_DEC, E_DEC_ILL, E_MADR, E_MRD, E_MWB, E_MWR;
  logic [23:0] E_EXE, E_AWB, E_BEQ, E_BNE, E_ORI_EX, E_ORI_WB, E_ADDI_EX, E_ADDI_WB, E_JMP;

  mc_control_unit dut_a (
    .cclk(cclk), .rst(rst_a), .Instr(instr_a), .mem_ready(ready_a),
    .MemReq(a_memreq), .IorD(a_iord), .MemtoReg(a_m2r), .ALUSrcA(a_srca),
    .ExtOp(a_ext), .RegDst(a_rdst), .PCSrc(a_pcsrc), .ALUSrcB(a_srcb),
    .IRWrite(a_irw), .MemWrite(a_mw), .PCWrite(a_pcw), .RegWrite(a_rw),
    .PCWriteCond(a_pcwc), .ALUOp(a_aluop), .illegal_op(a_ill), .state_dbg(a_state)
  );

  mc_control_unit #(
    .MEM_HANDSHAKE(1'b0), .EN_BNE(1'b0), .EN_LOGIC_IMM(1'b0)
  ) dut_b (
    .cclk(cclk), .rst(rst_b), .Instr(instr_b), .mem_ready(ready_b),
    .MemReq(b_memreq), .IorD(b_iord), .MemtoReg(b_m2r), .ALUSrcA(b_srca),
    .ExtOp(b_ext), .RegDst(b_rdst), .PCSrc(b_pcsrc), .ALUSrcB(b_srcb),
    .IRWrite(b_irw), .MemWrite(b_mw), .PCWrite(b_pcw), .RegWrite(b_rw),
    .PCWriteCond(b_pcwc), .ALUOp(b_aluop), .illegal_op(b_ill), .state_dbg(b_state)
  );

  assign act_a = {a_state, a_memreq, a_iord, a_m2r, a_srca, a_ext, a_rdst, a_pcsrc, a_srcb,
                  a_irw, a_mw, a_pcw, a_rw, a_pcwc, a_aluop, a_ill};
  assign act_b = {b_state, b_memreq, b_iord, b_m2r, b_srca, b_ext, b_rdst, b_pcsrc, b_srcb,
                  b_irw, b_mw, b_pcw, b_rw, b_pcwc, b_aluop, b_ill};

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [23:0] mk(input logic [3:0] st,
                                     input logic mreq, iord, m2r, srca, ext, rdst,
                                     input logic [1:0] pcsrc, srcb,
                                     input logic irw, mw, pcw, rw,
                                     input logic [1:0] pcwc,
                                     input logic [2:0] aluop,
                                     input logic ill);
    return {st, mreq, iord, m2r, srca, ext, rdst, pcsrc, srcb, irw, mw, pcw, rw, pcwc, aluop, ill};
  endfunction

  task automatic step_a(input logic r, input logic [31:0] ins, input logic rdy,
                        input logic [23:0] e, input string tag);
    @(posedge cclk);
    #1;
    rst_a = r; instr_a = ins; ready_a = rdy;
    qa_v.push_back(e); qa_t.push_back(tag);
  endtask

  task automatic step_b(input logic r, input logic [31:0] ins,
                        input logic [23:0] e, input string tag);
    @(posedge cclk);
    #1;
    rst_b = r; instr_b = ins;
    qb_v.push_back(e); qb_t.push_back(tag);
  endtask

  // Monitor: compare each DUT against the expected vector queued for this cycle
  always @(negedge cclk) begin
    if (qa_v.size() > 0) begin
      mon_exp = qa_v.pop_front();
      mon_tag = qa_t.pop_front();
      checks++;
      if (act_a !== mon_exp) begin
        errors++;
        $display("FAIL a.%s: got %h required %h", mon_tag, act_a, mon_exp);
      end
    end
    if (qb_v.size() > 0) begin
      mon_exp = qb_v.pop_front();
      mon_tag = qb_t.pop_front();
      checks++;
      if (act_b !== mon_exp) begin
        errors++;
        $display("FAIL b.%s: got %h required %h", mon_tag, act_b, mon_exp);
      end
    end
  end

  initial begin
    //                st    mrq io m2r sa ext rd pcsrc  srcb  irw mw pcw rw pcwc   aluop  ill
    E_ZERO    = '0;
    E_FETCH   = mk(4'd0,  1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 1, 0, 1, 0, 2'b00, 3'b000, 0);
    E_FETCH_W = mk(4'd0,  1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    E_DEC     = mk(4'd1,  0, 0, 0, 0, 1, 0, 2'b00, 2'b11, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    E_DEC_ILL = mk(4'd1,  0, 0, 0, 0, 1, 0, 2'b00, 2'b11, 0, 0, 0, 0, 2'b00, 3'b000, 1);
    E_MADR    = mk(4'd2,  0, 0, 0, 1, 1, 0, 2'b00, 2'b10, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    E_MRD     = mk(4'd3,  1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    E_MWB     = mk(4'd4,  0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 2'b00, 3'b000, 0);
    E_MWR     = mk(4'd5,  1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 2'b00, 3'b000, 0);
    E_EXE     = mk(4'd6,  0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 3'b010, 0);
    E_AWB     = mk(4'd7,  0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 1, 2'b00, 3'b000, 0);
    E_BEQ     = mk(4'd8,  0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 3'b001, 0);
    E_BNE     = mk(4'd8,  0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b10, 3'b001, 0);
    E_ORI_EX  = mk(4'd9,  0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0, 2'b00, 3'b100, 0);
    E_ORI_WB  = mk(4'd10, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 2'b00, 3'b100, 0);
    E_ADDI_EX = mk(4'd9,  0, 0, 0, 1, 1, 0, 2'b00, 2'b10, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    E_ADDI_WB = mk(4'd10, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 1, 2'b00, 3'b000, 0);
    E_JMP     = mk(4'd11, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 1, 0, 2'b00, 3'b000, 0);

    rst_a = 1'b1; instr_a = I_SW; ready_a = 1'b0;
    rst_b = 1'b1; instr_b = I_LW; ready_b = 1'b0;

    // dut_a: reset, then SW into a MEM_WRITE stall, reset again mid-stall
    step_a(1, I_SW, 0, E_ZERO,    "reset0");
    step_a(1, I_SW, 0, E_ZERO,    "reset1");
    step_a(0, I_SW, 1, E_FETCH,   "sw0_fetch");
    step_a(0, I_SW, 1, E_DEC,     "sw0_decode");
    step_a(0, I_SW, 1, E_MADR,    "sw0_memadr");
    step_a(0, I_SW, 0, E_MWR,     "sw0_stall0");
    step_a(0, I_SW, 0, E_MWR,     "sw0_stall1");
    for (int i = 0; i < 3; i++)
      step_a(1, I_SW, 0, E_ZERO,  "rst_in_stall");
    step_a(0, I_LW, 1, E_FETCH,   "rst_release_fetch");
    // LW, all memory ready
    step_a(0, I_LW, 1, E_DEC,     "lw_decode");
    step_a(0, I_LW, 1, E_MADR,    "lw_memadr");
    step_a(0, I_LW, 1, E_MRD,     "lw_memread");
    step_a(0, I_LW, 1, E_MWB,     "lw_memwb");
    // FETCH stall, then SW with three stall cycles in MEM_WRITE
    step_a(0, I_SW, 0, E_FETCH_W, "fetch_stall");
    step_a(0, I_SW, 1, E_FETCH,   "sw_fetch");
    step_a(0, I_SW, 1, E_DEC,     "sw_decode");
    step_a(0, I_SW, 1, E_MADR,    "sw_memadr");
    for (int i = 0; i < 3; i++)
      step_a(0, I_SW, 0, E_MWR,   "sw_stall");
    step_a(0, I_SW, 1, E_MWR,     "sw_complete");
    // R-type
    step_a(0, I_R, 1, E_FETCH,    "r_fetch");
    step_a(0, I_R, 1, E_DEC,      "r_decode");
    step_a(0, I_R, 1, E_EXE,      "r_execute");
    step_a(0, I_R, 1, E_AWB,      "r_aluwb");
    // BEQ and BNE
    step_a(0, I_BEQ, 1, E_FETCH,  "beq_fetch");
    step_a(0, I_BEQ, 1, E_DEC,    "beq_decode");
    step_a(0, I_BEQ, 1, E_BEQ,    "beq_branch");
    step_a(0, I_BNE, 1, E_FETCH,  "bne_fetch");
    step_a(0, I_BNE, 1, E_DEC,    "bne_decode");
    step_a(0, I_BNE, 1, E_BNE,    "bne_branch");
    // ORI and ADDI
    step_a(0, I_ORI, 1, E_FETCH,  "ori_fetch");
    step_a(0, I_ORI, 1, E_DEC,    "ori_decode");
    step_a(0, I_ORI, 1, E_ORI_EX, "ori_ex");
    step_a(0, I_ORI, 1, E_ORI_WB, "ori_wb");
    step_a(0, I_ADDI, 1, E_FETCH,   "addi_fetch");
    step_a(0, I_ADDI, 1, E_DEC,     "addi_decode");
    step_a(0, I_ADDI, 1, E_ADDI_EX, "addi_ex");
    step_a(0, I_ADDI, 1, E_ADDI_WB, "addi_wb");
    // Jump
    step_a(0, I_J, 1, E_FETCH,    "j_fetch");
    step_a(0, I_J, 1, E_DEC,      "j_decode");
    step_a(0, I_J, 1, E_JMP,      "j_jump");
    // Illegal opcode 63
    step_a(0, I_BAD, 1, E_FETCH,   "bad_fetch");
    step_a(0, I_BAD, 1, E_DEC_ILL, "bad_decode");
    step_a(0, I_BAD, 0, E_FETCH_W, "bad_back_to_fetch");
    // LW with one MEM_READ stall
    step_a(0, I_LW, 1, E_FETCH,   "lw2_fetch");
    step_a(0, I_LW, 1, E_DEC,     "lw2_decode");
    step_a(0, I_LW, 1, E_MADR,    "lw2_memadr");
    step_a(0, I_LW, 0, E_MRD,     "lw2_read_stall");
    step_a(0, I_LW, 1, E_MRD,     "lw2_read_done");
    step_a(0, I_LW, 1, E_MWB,     "lw2_memwb");
    // Reset landing on an illegal DECODE must not pulse illegal_op
    step_a(0, I_BAD, 1, E_FETCH,  "bad2_fetch");
    step_a(1, I_BAD, 1, E_ZERO,   "rst_in_bad_decode");
    step_a(0, I_R, 0, E_FETCH_W,  "after_rst_fetch");

    @(posedge cclk);
    #1;
    rst_a = 1'b1;

    // dut_b: mem_ready held low and ignored; BNE and ORI are illegal
    step_b(1, I_LW,  E_ZERO,    "reset");
    step_b(0, I_LW,  E_FETCH,   "lw_fetch");
    step_b(0, I_LW,  E_DEC,     "lw_decode");
    step_b(0, I_LW,  E_MADR,    "lw_memadr");
    step_b(0, I_LW,  E_MRD,     "lw_memread");
    step_b(0, I_LW,  E_MWB,     "lw_memwb");
    step_b(0, I_BNE, E_FETCH,   "bne_fetch");
    step_b(0, I_BNE, E_DEC_ILL, "bne_illegal");
    step_b(0, I_ORI, E_FETCH,   "ori_fetch");
    step_b(0, I_ORI, E_DEC_ILL, "ori_illegal");
    step_b(0, I_SW,  E_FETCH,   "sw_fetch");
    step_b(0, I_SW,  E_DEC,     "sw_decode");
    step_b(0, I_SW,  E_MADR,    "sw_memadr");
    step_b(0, I_SW,  E_MWR,     "sw_memwrite");
    step_b(0, I_BEQ, E_FETCH,   "beq_fetch");
    step_b(0, I_BEQ, E_DEC,     "beq_decode");
    step_b(0, I_BEQ, E_BEQ,     "beq_branch");
    step_b(0, I_BEQ, E_FETCH,   "final_fetch");

    @(negedge cclk);
    #1;
    checks++;
    if (qa_v.size() != 0 || qb_v.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending entries required 0/0", qa_v.size(), qb_v.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
